// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the instruction-fetch front end.
//   fetch_state_t    - fetch controller states (BOOT, RUN, DROP)
//   RESET_PC_DEFAULT - default first fetch address
//   INSTR_NOP        - canonical RV32I no-op encoding (addi x0, x0, 0)
package riscv_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned RESET_PC_DEFAULT = 32'd0;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular queue with synchronous reset and flush.
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   flush_i   - empties the queue; dominates push and pop in the same cycle
//   push_i    - write data_i (ignored when full unless a pop frees a slot)
//   pop_i     - drop the head entry (ignored when empty)
//   data_o    - head entry (meaningful only while !empty_o)
//   full_o, empty_o, count_o - occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Next-state for pointers and occupancy; flush returns to the empty state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so the head never exposes X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect/flush and a small
// instruction queue towards decode.
//   clk, rst                        - clock, synchronous active-high reset
//   imem_req_valid/addr/ready       - fetch request to instruction memory
//   imem_rsp_valid/data             - response, exactly one cycle after accept
//   redirect_valid/redirect_pc      - taken branch/jump: flush and refetch
//   out_valid/out_ready             - instruction handshake with decode
//   out_instr/out_pc                - queue-head instruction and its address
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned RESET_PC      = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = ADDRESS_WIDTH + DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC_L = ADDRESS_WIDTH'(RESET_PC);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                     inflight_q, inflight_d;
    logic                     drop_q, drop_d;

    logic                     accept_s, push_s, pop_s;
    logic                     fifo_full_s, fifo_empty_s;
    logic [CW-1:0]            fifo_count_s;
    logic [CW:0]              occupancy_s;
    logic [EW-1:0]            fifo_din_s, fifo_dout_s;

    // Queue entries plus the outstanding request must fit, so a response
    // always has a slot and the queue can never overflow.
    assign occupancy_s    = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q};
    assign imem_req_valid = (state_q == FS_RUN) && !redirect_valid
                            && (occupancy_s < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept_s       = imem_req_valid && imem_req_ready;

    // A redirect in the response cycle kills that response (flush wins).
    assign push_s     = imem_rsp_valid && inflight_q && !drop_q
                        && !redirect_valid && !fifo_full_s;
    assign pop_s      = out_valid && out_ready;
    assign fifo_din_s = {inflight_pc_q, imem_rsp_data};

    assign out_valid  = !fifo_empty_s;
    assign out_pc     = out_valid ? fifo_dout_s[EW-1:DATA_WIDTH]
                                  : {ADDRESS_WIDTH{1'b0}};
    assign out_instr  = out_valid ? fifo_dout_s[DATA_WIDTH-1:0]
                                  : {DATA_WIDTH{1'b0}};

    // Controller next-state: DROP covers the cycle after a redirect that
    // caught a request in flight.
    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN: begin
                if (redirect_valid && inflight_q) begin
                    state_d = FS_DROP;
                    drop_d  = 1'b1;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_DROP: state_d = FS_RUN;
            default: state_d = FS_BOOT;
        endcase
    end

    // Fetch address and in-flight tracking; redirect has priority.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = accept_s;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end else if (accept_s) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(3'd4);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (accept_s) begin
            inflight_pc_d = fetch_pc_q;
        end else begin
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Controller and fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_BOOT;
            fetch_pc_q    <= {RESET_PC_L[ADDRESS_WIDTH-1:2], 2'b00};
            inflight_pc_q <= {ADDRESS_WIDTH{1'b0}};
            inflight_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (fifo_din_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;

    int total = 0;
    int bad   = 0;
    logic [15:0] req_log[$];
    logic [15:0] pop_log[$];

    fetch_unit #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (16),
        .FIFO_DEPTH    (2),
        .RESET_PC      (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: instruction word derived from its address.
    function automatic logic [31:0] mk(input logic [15:0] a);
        return {~a, a};
    endfunction

    // One clock: log handshakes before the edge, answer accepted request after it.
    task automatic step();
        logic        acc;
        logic [15:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (acc) req_log.push_back(a);
        if (out_valid && out_ready) begin
            pop_log.push_back(out_pc);
            total++;
            if (out_instr !== mk(out_pc)) begin
                bad++;
                $display("FAIL pop_data pc=%h got=%h want=%h", out_pc, out_instr, mk(out_pc));
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = acc;
        imem_rsp_data  = acc ? mk(a) : 32'h0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h want=0", out_instr); end
        total++; if (out_pc !== 16'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc); end
    endtask

    task automatic test_startup();
        rst = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        req_log.delete(); pop_log.delete();
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", imem_req_valid); end
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin bad++; $display("FAIL start_req0 got=%b/%h want=1/0000", imem_req_valid, imem_req_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL start_early_out got=%b want=0", out_valid); end
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0004) begin bad++; $display("FAIL start_req4 got=%b/%h want=1/0004", imem_req_valid, imem_req_addr); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== mk(16'h0000)) begin bad++; $display("FAIL start_out0 got=%b/%h/%h want=1/0000/%h", out_valid, out_pc, out_instr, mk(16'h0000)); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL start_credit got=%b want=0", imem_req_valid); end
        step();
        total++; if (out_pc !== 16'h0004 || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0008) begin bad++; $display("FAIL start_out4 got=%h/%b/%h want=0004/1/0008", out_pc, imem_req_valid, imem_req_addr); end
        repeat (6) step();
        total++;
        if (req_log.size() < 3) begin bad++; $display("FAIL start_reqs got=%0d want>=3", req_log.size()); end
        else if (req_log[0] !== 16'h0000 || req_log[1] !== 16'h0004 || req_log[2] !== 16'h0008) begin
            bad++; $display("FAIL start_reqs got=%h,%h,%h want=0000,0004,0008", req_log[0], req_log[1], req_log[2]);
        end
    endtask

    task automatic test_stall();
        rst = 1'b1; step();
        rst = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
        req_log.delete(); pop_log.delete();
        repeat (6) step();
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== mk(16'h0000)) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h want=1/0000/%h", i, out_valid, out_pc, out_instr, mk(16'h0000));
            end
        end
        total++; if (req_log.size() != 2) begin bad++; $display("FAIL stall_reqs got=%0d want=2", req_log.size()); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", imem_req_valid); end
    endtask

    task automatic test_redirect_idle();
        redirect_valid = 1'b1; redirect_pc = 16'h0203;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_block got=%b want=0", imem_req_valid); end
        step();
        redirect_valid = 1'b0; req_log.delete(); pop_log.delete();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", out_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0200) begin bad++; $display("FAIL redir_next_req got=%b/%h want=1/0200", imem_req_valid, imem_req_addr); end
        out_ready = 1'b1;
        repeat (4) step();
        total++;
        if (pop_log.size() < 1 || pop_log[0] !== 16'h0200) begin bad++; $display("FAIL redir_first_out n=%0d want first=0200", pop_log.size()); end
    endtask

    task automatic test_redirect_inflight();
        rst = 1'b1; step();
        rst = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 16'h0102;
        req_log.delete(); pop_log.delete();
        #1;
        total++; if (imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL drop_setup rsp got=%b want=1", imem_rsp_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_out got=%b want=0", out_valid); end
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100) begin bad++; $display("FAIL drop_next_req got=%b/%h want=1/0100", imem_req_valid, imem_req_addr); end
        repeat (5) step();
        total++;
        if (pop_log.size() < 1 || pop_log[0] !== 16'h0100) begin bad++; $display("FAIL drop_first_out n=%0d want first=0100", pop_log.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] nxt;
        redirect_valid = 1'b1; redirect_pc = 16'h0301; step();
        redirect_pc = 16'h0404; step();
        redirect_valid = 1'b0; req_log.delete(); pop_log.delete();
        repeat (10) step();
        total++;
        if (pop_log.size() < 3 || pop_log[0] !== 16'h0404) begin bad++; $display("FAIL b2b_first n=%0d want first=0404", pop_log.size()); end
        for (int i = 1; i < pop_log.size(); i++) begin
            nxt = pop_log[i-1] + 16'h0004;
            total++;
            if (pop_log[i] !== nxt) begin bad++; $display("FAIL b2b_seq idx=%0d got=%h want=%h", i, pop_log[i], nxt); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [3];
        exp_w = '{16'hFFF8, 16'hFFFC, 16'h0000};
        redirect_valid = 1'b1; redirect_pc = 16'hFFF8; step();
        redirect_valid = 1'b0; req_log.delete(); pop_log.delete();
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req_log.size() <= i || req_log[i] !== exp_w[i]) begin bad++; $display("FAIL wrap_req idx=%0d want=%h", i, exp_w[i]); end
            total++;
            if (pop_log.size() <= i || pop_log[i] !== exp_w[i]) begin bad++; $display("FAIL wrap_out idx=%0d want=%h", i, exp_w[i]); end
        end
    endtask

    task automatic test_ready_toggle();
        logic [15:0] nxt;
        redirect_valid = 1'b1; redirect_pc = 16'h0500; step();
        redirect_valid = 1'b0; req_log.delete(); pop_log.delete();
        for (int i = 0; i < 24; i++) begin
            imem_req_ready = (i % 2 == 0);
            step();
        end
        imem_req_ready = 1'b1;
        total++;
        if (pop_log.size() < 4 || pop_log[0] !== 16'h0500) begin bad++; $display("FAIL tog_first n=%0d want>=4 first=0500", pop_log.size()); end
        for (int i = 1; i < pop_log.size(); i++) begin
            nxt = pop_log[i-1] + 16'h0004;
            total++;
            if (pop_log[i] !== nxt) begin bad++; $display("FAIL tog_seq idx=%0d got=%h want=%h", i, pop_log[i], nxt); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0700; step();
        redirect_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0704) begin bad++; $display("FAIL rmid_setup got=%b/%h want=1/0704", imem_req_valid, imem_req_addr); end
        step();
        total++; if (out_valid !== 1'b0 || out_pc !== 16'h0) begin bad++; $display("FAIL rmid_out got=%b/%h want=0/0000", out_valid, out_pc); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=0", imem_req_valid); end
        rst = 1'b0; out_ready = 1'b1; req_log.delete(); pop_log.delete();
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_boot got=%b want=0", imem_req_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b want=0", out_valid); end
        repeat (6) step();
        total++;
        if (pop_log.size() < 1 || pop_log[0] !== 16'h0000) begin bad++; $display("FAIL rmid_first n=%0d want first=0000", pop_log.size()); end
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 16'h0; out_ready = 1'b0;
        test_reset();
        test_startup();
        test_stall();
        test_redirect_idle();
        test_redirect_inflight();
        test_back_to_back();
        test_wrap();
        test_ready_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
